// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: two requester ports, arbiter response and data-memory bus; master = requesters+memory side, slave = arbiter
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  p0_req;
  logic                  p0_we;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_ack;
  logic                  p1_req;
  logic                  p1_we;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_ack;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_dataIn;
  logic                  mem_writeEnable;
  logic [DATA_WIDTH-1:0] mem_dataOut;
  logic                  busy;
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata, mem_dataOut,
    input  p0_ack, p1_ack, rdata, mem_address, mem_dataIn, mem_writeEnable, busy
  );
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata, mem_dataOut,
    output p0_ack, p1_ack, rdata, mem_address, mem_dataIn, mem_writeEnable, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port data-memory arbiter (IDLE/ACCESS/RESP), clk/reset plus dmem_arbiter_if.slave bus; define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority, round-robin otherwise
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t                state, state_nx;
  logic                  id_q, we_q, any, win;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  assign any = bus.p0_req | bus.p1_req;
`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign win = ~bus.p0_req;
`else
  logic ptr;
  assign win = (bus.p0_req & bus.p1_req) ? ptr : ~bus.p0_req;
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= 1'b0;
    else if (state == IDLE && any) ptr <= ~win;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (any ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
    bus.busy = state != IDLE;
    bus.mem_writeEnable = state == ACCESS && we_q;
    bus.p0_ack = state == RESP && !id_q;
    bus.p1_ack = state == RESP && id_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && any) begin
        id_q    <= win;
        we_q    <= win ? bus.p1_we : bus.p0_we;
        addr_q  <= win ? bus.p1_addr : bus.p0_addr;
        wdata_q <= win ? bus.p1_wdata : bus.p0_wdata;
      end
      if (state == ACCESS && !we_q) rdata_q <= bus.mem_dataOut;
    end
  assign bus.mem_address = addr_q;
  assign bus.mem_dataIn  = wdata_q;
  assign bus.rdata       = rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random stimulus checked against a transaction-level reference model
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic mem_init;
  logic [31:0] mem [16];
  int tests = 0;
  int fails = 0;
  int phase;
  bit win, wwe, ptr;
  logic [31:0] waddr, wdat, e_rdata, e_addr, e_din;
  logic [31:0] rmem [16];
  int a0c, a1c;
  always #5 clk = ~clk;
  dmem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always @(posedge clk)
    if (mem_init) for (int i = 0; i < 16; i++) mem[i] <= 32'h12345670 + i;
    else if (bus.mem_writeEnable) mem[bus.mem_address[3:0]] <= bus.mem_dataIn;
  assign bus.mem_dataOut = mem[bus.mem_address[3:0]];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    phase = 0; ptr = 0; win = 0; wwe = 0;
    e_rdata = 0; e_addr = 0; e_din = 0;
  endtask
  task automatic check_all();
    chk("busy", {31'd0, bus.busy}, {31'd0, phase != 0});
    chk("mem_we", {31'd0, bus.mem_writeEnable}, {31'd0, phase == 1 && wwe});
    chk("p0_ack", {31'd0, bus.p0_ack}, {31'd0, phase == 2 && !win});
    chk("p1_ack", {31'd0, bus.p1_ack}, {31'd0, phase == 2 && win});
    chk("rdata", bus.rdata, e_rdata);
    chk("mem_address", bus.mem_address, e_addr);
    chk("mem_dataIn", bus.mem_dataIn, e_din);
  endtask
  task automatic model_edge();
    if (phase == 0) begin
      if (bus.p0_req || bus.p1_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        win = !bus.p0_req;
`else
        win = (bus.p0_req && bus.p1_req) ? ptr : !bus.p0_req;
`endif
        ptr = !win;
        wwe = win ? bus.p1_we : bus.p0_we;
        waddr = win ? bus.p1_addr : bus.p0_addr;
        wdat = win ? bus.p1_wdata : bus.p0_wdata;
        e_addr = waddr;
        e_din = wdat;
        phase = 1;
      end
    end else if (phase == 1) begin
      if (wwe) rmem[waddr[3:0]] = wdat;
      else e_rdata = rmem[waddr[3:0]];
      phase = 2;
    end else phase = 0;
  endtask
  task automatic cyc(input logic r0, w0, input logic [31:0] a0, d0, input logic r1, w1, input logic [31:0] a1, d1);
    bus.p0_req = r0; bus.p0_we = w0; bus.p0_addr = a0; bus.p0_wdata = d0;
    bus.p1_req = r1; bus.p1_we = w1; bus.p1_addr = a1; bus.p1_wdata = d1;
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    if (bus.p0_ack) a0c++;
    if (bus.p1_ack) a1c++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    reset = 1; mem_init = 1;
    bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = 0; bus.p0_wdata = 0;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = 0; bus.p1_wdata = 0;
    model_reset();
    for (int i = 0; i < 16; i++) rmem[i] = 32'h12345670 + i;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 0; mem_init = 0;
    cyc(1, 1, 32'h4, 32'hDEADBEEF, 0, 0, 0, 0);
    idle(2);
    cyc(1, 0, 32'h4, 32'h0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("wr_rd_ack", {31'd0, bus.p0_ack}, 32'd1);
    chk("wr_rd_data", bus.rdata, 32'hDEADBEEF);
    idle(1);
    cyc(0, 0, 0, 0, 1, 0, 32'h8, 0);
    cyc(0, 0, 0, 0, 1, 0, 32'hC, 0);
    chk("addr_hold", bus.mem_address, 32'h8);
    chk("addr_hold_data", bus.rdata, 32'h12345678);
    chk("addr_hold_ack", {31'd0, bus.p1_ack}, 32'd1);
    idle(1);
    a0c = 0; a1c = 0;
    for (int i = 0; i < 12; i++) cyc(1, 0, $urandom_range(15), 0, 1, 0, $urandom_range(15), 0);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    chk("both_p0_acks", a0c, 4);
    chk("both_p1_starved", a1c, 0);
`else
    chk("rr_p0_acks", a0c, 2);
    chk("rr_p1_acks", a1c, 2);
`endif
    idle(3);
    cyc(0, 0, 0, 0, 1, 1, 32'h3, 32'hCAFEF00D);
    chk("pre_reset_we", {31'd0, bus.mem_writeEnable}, 32'd1);
    #2;
    reset = 1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 0;
    cyc(1, 0, 32'h5, 0, 1, 0, 32'h6, 0);
    chk("post_reset_grant", bus.mem_address, 32'h5);
    idle(2);
    cyc(1, 0, 32'h3, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("dropped_write", bus.rdata, 32'h12345673);
    idle(1);
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(1), $urandom_range(1), $urandom_range(15), $urandom,
          $urandom_range(1), $urandom_range(1), $urandom_range(15), $urandom);
    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
